// File: rtl/tron_pkg.sv
// Shared types for the Tron score keeper: match FSM states, winner codes and score widths.
package tron_pkg;

    localparam int unsigned BCD_W   = 4;
    localparam int unsigned SCORE_W = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        PAUSE = 2'd2,
        OVER  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_P1   = 2'b01,
        WIN_P2   = 2'b10,
        WIN_DRAW = 2'b11
    } winner_t;

    // Both players past the target is a draw; otherwise the one that got there.
    function automatic winner_t pick_winner(input logic p1_won, input logic p2_won);
        if (p1_won && p2_won) begin
            return WIN_DRAW;
        end
        if (p1_won) begin
            return WIN_P1;
        end
        if (p2_won) begin
            return WIN_P2;
        end
        return WIN_NONE;
    endfunction

endpackage

// File: rtl/bcd_counter_2d.sv
// Two-digit BCD up-counter with synchronous clear, saturating at 99.
// Also exposes its binary equivalent for threshold compares.
module bcd_counter_2d
    import tron_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               inc,
    output logic [BCD_W-1:0]   tens,
    output logic [BCD_W-1:0]   units,
    output logic [SCORE_W-1:0] value_c
);

    logic at_max;

    assign at_max  = (tens == BCD_W'(9)) && (units == BCD_W'(9));
    assign value_c = SCORE_W'(tens) * SCORE_W'(10) + SCORE_W'(units);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tens  <= '0;
            units <= '0;
        end else if (clr) begin
            tens  <= '0;
            units <= '0;
        end else if (inc && !at_max) begin
            if (units == BCD_W'(9)) begin
                units <= '0;
                tens  <= tens + BCD_W'(1);
            end else begin
                units <= units + BCD_W'(1);
            end
        end
    end

endmodule

// File: rtl/tron_score_keeper.sv
// Tron match controller: round sequencing, post-crash pause and per-player BCD scores.
// Define TRON_SCORE_DRAW_POINT_EN to award a point to both players on a simultaneous crash.
module tron_score_keeper
    import tron_pkg::*;
#(
    parameter int unsigned WIN_SCORE    = 10,
    parameter int unsigned PAUSE_CYCLES = 100_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_btn,
    input  logic             p1_crash,
    input  logic             p2_crash,
    output logic             round_active,
    output logic             round_reset,
    output logic             match_over,
    output logic [1:0]       winner,
    output logic [BCD_W-1:0] player1_score_tens,
    output logic [BCD_W-1:0] player1_score_units,
    output logic [BCD_W-1:0] player2_score_tens,
    output logic [BCD_W-1:0] player2_score_units
);

    localparam int unsigned          CNT_W    = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(PAUSE_CYCLES - 1);
    localparam logic [SCORE_W-1:0]   WIN_VAL  = SCORE_W'(WIN_SCORE);

    state_t             state;
    logic               start_q;
    logic [CNT_W-1:0]   pause_cnt;
    logic               start_pulse;
    logic               any_crash;
    logic               play_crash;
    logic               p1_inc;
    logic               p2_inc;
    logic               clr_scores;
    logic [SCORE_W-1:0] p1_value;
    logic [SCORE_W-1:0] p2_value;
    logic               p1_won;
    logic               p2_won;

    assign start_pulse = start_btn & ~start_q;
    assign any_crash   = p1_crash | p2_crash;
    assign play_crash  = (state == PLAY) & any_crash;
    assign clr_scores  = (state == OVER) & start_pulse;
    assign p1_won      = (p1_value >= WIN_VAL);
    assign p2_won      = (p2_value >= WIN_VAL);

    // A crash scores for the opponent; a simultaneous crash is a draw round.
`ifdef TRON_SCORE_DRAW_POINT_EN
    assign p1_inc = play_crash & p2_crash;
    assign p2_inc = play_crash & p1_crash;
`else
    assign p1_inc = play_crash & p2_crash & ~p1_crash;
    assign p2_inc = play_crash & p1_crash & ~p2_crash;
`endif

    bcd_counter_2d u_p1_score (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr_scores),
        .inc     (p1_inc),
        .tens    (player1_score_tens),
        .units   (player1_score_units),
        .value_c (p1_value)
    );

    bcd_counter_2d u_p2_score (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr_scores),
        .inc     (p2_inc),
        .tens    (player2_score_tens),
        .units   (player2_score_units),
        .value_c (p2_value)
    );

    // Match sequencing; round_reset is a one-cycle strobe on every entry into PLAY.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            start_q      <= 1'b0;
            pause_cnt    <= '0;
            round_active <= 1'b0;
            round_reset  <= 1'b0;
            match_over   <= 1'b0;
            winner       <= WIN_NONE;
        end else begin
            start_q     <= start_btn;
            round_reset <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_pulse) begin
                        state        <= PLAY;
                        round_reset  <= 1'b1;
                        round_active <= 1'b1;
                    end
                end
                PLAY: begin
                    if (any_crash) begin
                        state        <= PAUSE;
                        pause_cnt    <= '0;
                        round_active <= 1'b0;
                    end
                end
                PAUSE: begin
                    if (pause_cnt == CNT_LAST) begin
                        if (p1_won || p2_won) begin
                            state      <= OVER;
                            match_over <= 1'b1;
                            winner     <= pick_winner(p1_won, p2_won);
                        end else begin
                            state        <= PLAY;
                            round_reset  <= 1'b1;
                            round_active <= 1'b1;
                        end
                    end else begin
                        pause_cnt <= pause_cnt + CNT_W'(1);
                    end
                end
                OVER: begin
                    if (start_pulse) begin
                        state        <= PLAY;
                        match_over   <= 1'b0;
                        winner       <= WIN_NONE;
                        round_reset  <= 1'b1;
                        round_active <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tron_score_keeper.sv
// Self-checking bench: two score keepers (WIN_SCORE 10 and 99) share random stimulus
// and are compared every cycle against a score-level match model.
module tb_tron_score_keeper;

    localparam int unsigned PAUSE = 4;
    localparam int M_IDLE  = 0;
    localparam int M_PLAY  = 1;
    localparam int M_PAUSE = 2;
    localparam int M_OVER  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_btn = 1'b0;
    logic p1_crash = 1'b0;
    logic p2_crash = 1'b0;

    logic       ra [2];
    logic       rr [2];
    logic       mo [2];
    logic [1:0] wn [2];
    logic [3:0] p1t [2];
    logic [3:0] p1u [2];
    logic [3:0] p2t [2];
    logic [3:0] p2u [2];

    int checks = 0;
    int errors = 0;

    // Reference model state per instance
    int m_win   [2];
    int m_mode  [2];
    int m_s1    [2];
    int m_s2    [2];
    int m_timer [2];
    int m_ra    [2];
    int m_rr    [2];
    int m_mo    [2];
    int m_wn    [2];
    int m_sprev [2];

    always #5 clk = ~clk;

    tron_score_keeper #(.WIN_SCORE(10), .PAUSE_CYCLES(PAUSE)) u_dut_a (
        .clk                 (clk),
        .rst                 (rst),
        .start_btn           (start_btn),
        .p1_crash            (p1_crash),
        .p2_crash            (p2_crash),
        .round_active        (ra[0]),
        .round_reset         (rr[0]),
        .match_over          (mo[0]),
        .winner              (wn[0]),
        .player1_score_tens  (p1t[0]),
        .player1_score_units (p1u[0]),
        .player2_score_tens  (p2t[0]),
        .player2_score_units (p2u[0])
    );

    tron_score_keeper #(.WIN_SCORE(99), .PAUSE_CYCLES(PAUSE)) u_dut_b (
        .clk                 (clk),
        .rst                 (rst),
        .start_btn           (start_btn),
        .p1_crash            (p1_crash),
        .p2_crash            (p2_crash),
        .round_active        (ra[1]),
        .round_reset         (rr[1]),
        .match_over          (mo[1]),
        .winner              (wn[1]),
        .player1_score_tens  (p1t[1]),
        .player1_score_units (p1u[1]),
        .player2_score_tens  (p2t[1]),
        .player2_score_units (p2u[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int add_point(input int s);
        return (s >= 99) ? 99 : s + 1;
    endfunction

    function automatic int decide(input int s1, input int s2, input int w);
        if (s1 >= w && s2 >= w) return 3;
        if (s1 >= w) return 1;
        return 2;
    endfunction

    task automatic model_reset(input int k);
        m_mode[k] = M_IDLE; m_s1[k] = 0; m_s2[k] = 0; m_timer[k] = 0;
        m_ra[k] = 0; m_rr[k] = 0; m_mo[k] = 0; m_wn[k] = 0; m_sprev[k] = 0;
    endtask

    task automatic enter_round(input int k);
        m_mode[k] = M_PLAY; m_rr[k] = 1; m_ra[k] = 1;
    endtask

    // One clock of match behaviour, from the inputs present at the edge
    task automatic model_step(input int k);
        bit sp;
        sp = start_btn && !m_sprev[k];
        m_sprev[k] = int'(start_btn);
        m_rr[k] = 0;
        case (m_mode[k])
            M_IDLE: if (sp) enter_round(k);
            M_PLAY: if (p1_crash || p2_crash) begin
                if (p1_crash && !p2_crash) m_s2[k] = add_point(m_s2[k]);
                else if (p2_crash && !p1_crash) m_s1[k] = add_point(m_s1[k]);
`ifdef TRON_SCORE_DRAW_POINT_EN
                else begin
                    m_s1[k] = add_point(m_s1[k]);
                    m_s2[k] = add_point(m_s2[k]);
                end
`endif
                m_mode[k] = M_PAUSE; m_timer[k] = PAUSE; m_ra[k] = 0;
            end
            M_PAUSE: begin
                m_timer[k]--;
                if (m_timer[k] == 0) begin
                    if (m_s1[k] >= m_win[k] || m_s2[k] >= m_win[k]) begin
                        m_mode[k] = M_OVER; m_mo[k] = 1;
                        m_wn[k] = decide(m_s1[k], m_s2[k], m_win[k]);
                    end else begin
                        enter_round(k);
                    end
                end
            end
            default: if (sp) begin
                m_s1[k] = 0; m_s2[k] = 0; m_wn[k] = 0; m_mo[k] = 0;
                enter_round(k);
            end
        endcase
    endtask

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("round_active[%0d]", k), 32'(ra[k]), 32'(m_ra[k]));
            check($sformatf("round_reset[%0d]", k), 32'(rr[k]), 32'(m_rr[k]));
            check($sformatf("match_over[%0d]", k), 32'(mo[k]), 32'(m_mo[k]));
            check($sformatf("winner[%0d]", k), 32'(wn[k]), 32'(m_wn[k]));
            check($sformatf("p1_tens[%0d]", k), 32'(p1t[k]), 32'(m_s1[k] / 10));
            check($sformatf("p1_units[%0d]", k), 32'(p1u[k]), 32'(m_s1[k] % 10));
            check($sformatf("p2_tens[%0d]", k), 32'(p2t[k]), 32'(m_s2[k] / 10));
            check($sformatf("p2_units[%0d]", k), 32'(p2u[k]), 32'(m_s2[k] % 10));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (rst) model_reset(k);
            else model_step(k);
        end
        #1;
        compare_all();
    endtask

    task automatic wait_mode(input int k, input int mode, input int budget);
        int n;
        n = 0;
        while (m_mode[k] != mode && n < budget) begin
            tick();
            n++;
        end
        check($sformatf("reach_mode%0d[%0d]", mode, k), 32'(m_mode[k]), 32'(mode));
    endtask

    // One scored round, then random crash noise in the first pause cycles
    task automatic do_round(input logic c1, input logic c2);
        p1_crash = c1; p2_crash = c2;
        tick();
        for (int i = 0; i < 2; i++) begin
            p1_crash = 1'($urandom_range(0, 1));
            p2_crash = 1'($urandom_range(0, 1));
            tick();
        end
        p1_crash = 1'b0; p2_crash = 1'b0;
    endtask

    initial begin
        int n;
        m_win[0] = 10;
        m_win[1] = 99;
        model_reset(0);
        model_reset(1);

        #2;
        compare_all();
        #10 rst = 1'b0;
        tick();
        tick();

        // Start with start_btn held through the first round
        start_btn = 1'b1;
        tick();
        check("first_round_reset", 32'(rr[0]), 32'd1);
        check("first_round_active", 32'(ra[0]), 32'd1);
        tick();
        tick();
        tick();
        p2_crash = 1'b1;
        tick();
        p2_crash = 1'b0;
        check("first_point_units", 32'(p1u[0]), 32'd1);
        check("first_point_inactive", 32'(ra[0]), 32'd0);
        start_btn = 1'b0;
        for (int i = 0; i < 2; i++) begin
            p1_crash = 1'($urandom_range(0, 1));
            tick();
        end
        p1_crash = 1'b0;

        // Nine more rounds to player 1 ends the WIN_SCORE=10 match
        for (int r = 0; r < 9; r++) begin
            wait_mode(0, M_PLAY, 20);
            do_round(1'b0, 1'b1);
        end
        wait_mode(0, M_OVER, 20);
        check("win10_over", 32'(mo[0]), 32'd1);
        check("win10_winner", 32'(wn[0]), 32'd1);
        check("win10_tens", 32'(p1t[0]), 32'd1);
        check("win10_units", 32'(p1u[0]), 32'd0);

        // Simultaneous crash on the still-running WIN_SCORE=99 match
        wait_mode(1, M_PLAY, 20);
        do_round(1'b1, 1'b1);
        wait_mode(1, M_PLAY, 20);

        // Random play including restarts of the finished match
        for (int i = 0; i < 300; i++) begin
            p1_crash  = ($urandom_range(0, 5) == 0);
            p2_crash  = ($urandom_range(0, 5) == 0);
            start_btn = ($urandom_range(0, 7) == 0);
            tick();
        end
        p1_crash = 1'b0; p2_crash = 1'b0; start_btn = 1'b0;

        // Drive player 2 of the WIN_SCORE=99 match to 99
        n = 0;
        while (m_s2[1] < 99 && n < 4000) begin
            p1_crash = (m_mode[1] == M_PLAY);
            tick();
            n++;
        end
        p1_crash = 1'b0;
        check("reach99_tens", 32'(p2t[1]), 32'd9);
        check("reach99_units", 32'(p2u[1]), 32'd9);
        tick();

        // Asynchronous reset in the middle of the pause
        #2 rst = 1'b1;
        #1;
        model_reset(0);
        model_reset(1);
        check("async_rst_tens", 32'(p2t[1]), 32'd0);
        check("async_rst_units", 32'(p2u[1]), 32'd0);
        compare_all();
        tick();
        tick();
        #2 rst = 1'b0;
        tick();
        tick();
        check("idle_after_rst", 32'(ra[1]), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
